// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the 68000 bus controller.
//   state_t     : bus-cycle FSM states
//   FC_IACK     : function code marking an interrupt-acknowledge cycle
//   ADDR_W      : width of one window base/mask field
//   WAIT_W      : width of one window wait-state field
//   win_hit()   : masked address compare for one window
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_END
  } state_t;

  localparam logic [2:0] FC_IACK = 3'b111;
  localparam int ADDR_W = 24;
  localparam int WAIT_W = 4;

  function automatic logic win_hit(input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W-1:0] base,
                                   input logic [ADDR_W-1:0] mask);
    return ((a ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/irq_encoder.sv
// Interrupt priority encoder.
// Two-flop synchronises the asynchronous IRQ lines, then registers the
// active-low encoding of the highest asserted level (IRQ line i = level i+1).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   irq_n      : interrupt requests, active-low, asynchronous
//   ipl_n      : encoded priority level to CPU, active-low, 3'b111 = none
module irq_encoder #(
  parameter int NUM_IRQ = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_n,
  output logic [2:0]         ipl_n
);

  logic [NUM_IRQ-1:0] sync1_n, sync2_n;
  logic [2:0]         level;

  // Ascending scan so the highest asserted line wins.
  always_comb begin
    level = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (!sync2_n[i]) level = 3'(i + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_n <= '1;
      sync2_n <= '1;
      ipl_n   <= 3'b111;
    end else begin
      sync1_n <= irq_n;
      sync2_n <= sync1_n;
      ipl_n   <= ~level;
    end
  end

endmodule

// File: rtl/bus_controller.sv
// 68000 bus controller: chip-select decode with boot overlay, DTACK
// generation (wait-state counter or external ack), interrupt IPL encode and
// IACK/VPA handling, and a bus-cycle watchdog that raises BERR.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   as_n, uds_n, lds_n  : CPU strobes, active-low
//   rw, fc, addr        : CPU read/write, function code, A[23:1]
//   cs_n                : chip selects, active-low
//   dtack_in_n          : external acks for externally-acked windows
//   iack_dtack_n        : ack from a vectored interrupt source
//   irq_n               : interrupt requests, active-low
//   iack_n              : per-level interrupt acknowledge, active-low
//   ipl_n               : encoded priority to CPU, active-low
//   dtack_n, vpa_n      : data ack / autovector request, active-low
//   berr_n              : bus error, active-low
//   boot                : 0 while the boot overlay is active
module bus_controller
  import bus_ctrl_pkg::*;
#(
  parameter int                       NUM_CS       = 4,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_BASE      = {24'h400000, 24'h800000, 24'h000000, 24'hF00000},
  parameter logic [NUM_CS*ADDR_W-1:0] CS_MASK      = {24'hF00000, 24'hF00000, 24'hF00000, 24'hF00000},
  parameter logic [NUM_CS*WAIT_W-1:0] CS_WAIT      = {4'd3, 4'd0, 4'd0, 4'd1},
  parameter logic [NUM_CS-1:0]        CS_EXT       = 4'b0100,
  parameter int                       BOOT_CS      = 0,
  parameter int                       BOOT_CYCLES  = 4,
  parameter int                       BERR_TIMEOUT = 64,
  parameter int                       NUM_IRQ      = 7,
  parameter logic [NUM_IRQ-1:0]       IRQ_VECTORED = 7'b0010000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               as_n,
  input  logic               uds_n,
  input  logic               lds_n,
  input  logic               rw,
  input  logic [2:0]         fc,
  input  logic [22:0]        addr,
  output logic [NUM_CS-1:0]  cs_n,
  input  logic [NUM_CS-1:0]  dtack_in_n,
  input  logic               iack_dtack_n,
  input  logic [NUM_IRQ-1:0] irq_n,
  output logic [NUM_IRQ-1:0] iack_n,
  output logic [2:0]         ipl_n,
  output logic               dtack_n,
  output logic               vpa_n,
  output logic               berr_n,
  output logic               boot
);

  localparam int WD_W = $clog2(BERR_TIMEOUT + 1);
  localparam int BC_W = $clog2(BOOT_CYCLES + 1);

  state_t              state;
  logic [22:0]         addr_q;
  logic [2:0]          fc_q;
  logic                rw_q;
  logic [NUM_CS-1:0]   sel_q;     // one-hot selected window
  logic                ext_q;     // selected window acks externally
  logic [NUM_IRQ-1:0]  iack_sel;  // one-hot vectored IACK level
  logic                auto_q;    // autovectored IACK cycle
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WD_W-1:0]     wd_cnt;
  logic [BC_W-1:0]     boot_cnt;

  // Direction is latched for completeness but no decode depends on it.
  logic rw_unused;
  assign rw_unused = rw_q;

  logic strobe;
  assign strobe = !(uds_n && lds_n);

  logic wd_exp;
  assign wd_exp = (wd_cnt == WD_W'(BERR_TIMEOUT - 1));

  // Window decode: overlay forces BOOT_CS, otherwise lowest matching window.
  logic [NUM_CS-1:0] hit_sel;
  logic              hit_any;
  logic              hit_ext;
  logic [WAIT_W-1:0] hit_wait;
  always_comb begin
    hit_sel  = '0;
    hit_any  = 1'b0;
    hit_ext  = 1'b0;
    hit_wait = '0;
    if (!boot) begin
      hit_sel[BOOT_CS] = 1'b1;
      hit_any          = 1'b1;
      hit_ext          = CS_EXT[BOOT_CS];
      hit_wait         = CS_WAIT[WAIT_W*BOOT_CS +: WAIT_W];
    end else begin
      for (int i = 0; i < NUM_CS; i++)
        if (!hit_any && win_hit({addr_q, 1'b0}, CS_BASE[ADDR_W*i +: ADDR_W],
                                CS_MASK[ADDR_W*i +: ADDR_W])) begin
          hit_sel[i] = 1'b1;
          hit_any    = 1'b1;
          hit_ext    = CS_EXT[i];
          hit_wait   = CS_WAIT[WAIT_W*i +: WAIT_W];
        end
    end
  end

  // IACK level decode from A[3:1]; out-of-range levels select nothing.
  logic [NUM_IRQ-1:0] lvl_onehot;
  logic               lvl_ok;
  logic               lvl_vec;
  always_comb begin
    lvl_onehot = '0;
    lvl_ok     = 1'b0;
    lvl_vec    = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (addr_q[2:0] == 3'(i + 1)) begin
        lvl_onehot[i] = 1'b1;
        lvl_ok        = 1'b1;
        lvl_vec       = IRQ_VECTORED[i];
      end
  end

  // Acknowledge condition while in WAIT.
  logic ack_now;
  always_comb begin
    ack_now = 1'b0;
    if (auto_q)        ack_now = 1'b1;
    else if (|iack_sel) ack_now = !iack_dtack_n;
    else if (ext_q)    ack_now = |(sel_q & ~dtack_in_n);
    else if (|sel_q)   ack_now = (wait_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      fc_q     <= '0;
      rw_q     <= 1'b1;
      sel_q    <= '0;
      ext_q    <= 1'b0;
      iack_sel <= '0;
      auto_q   <= 1'b0;
      wait_cnt <= '0;
      wd_cnt   <= '0;
      boot_cnt <= '0;
      boot     <= 1'b0;
      cs_n     <= '1;
      iack_n   <= '1;
      dtack_n  <= 1'b1;
      vpa_n    <= 1'b1;
      berr_n   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          wd_cnt <= '0;
          if (!as_n) begin
            addr_q <= addr;
            fc_q   <= fc;
            rw_q   <= rw;
            state  <= S_DECODE;
          end
        end

        S_DECODE: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (as_n) begin
            state <= S_END;
          end else if (wd_exp) begin
            berr_n <= 1'b0;
            state  <= S_ACK;
          end else begin
            if (fc_q == FC_IACK) begin
              sel_q    <= '0;
              ext_q    <= 1'b0;
              iack_sel <= lvl_vec ? lvl_onehot : '0;
              auto_q   <= lvl_ok && !lvl_vec;
              iack_n   <= lvl_vec ? ~lvl_onehot : '1;
              cs_n     <= '1;
            end else begin
              sel_q    <= hit_sel;
              ext_q    <= hit_any && hit_ext;
              wait_cnt <= hit_wait;
              iack_sel <= '0;
              auto_q   <= 1'b0;
              cs_n     <= strobe ? ~hit_sel : '1;
            end
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          cs_n   <= strobe ? ~sel_q : '1;
          if (as_n) begin
            // Cycle abandoned before any ack.
            cs_n   <= '1;
            iack_n <= '1;
            state  <= S_END;
          end else if (ack_now) begin
            // Ack beats a watchdog expiry on the same edge.
            dtack_n <= auto_q;
            vpa_n   <= !auto_q;
            state   <= S_ACK;
          end else if (wd_exp) begin
            berr_n <= 1'b0;
            cs_n   <= '1;
            iack_n <= '1;
            state  <= S_ACK;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end

        S_ACK: begin
          if (as_n) begin
            cs_n    <= '1;
            iack_n  <= '1;
            dtack_n <= 1'b1;
            vpa_n   <= 1'b1;
            berr_n  <= 1'b1;
            state   <= S_END;
          end
        end

        S_END: begin
          wd_cnt   <= '0;
          sel_q    <= '0;
          iack_sel <= '0;
          auto_q   <= 1'b0;
          ext_q    <= 1'b0;
          if (!boot) begin
            boot_cnt <= boot_cnt + BC_W'(1);
            if (boot_cnt == BC_W'(BOOT_CYCLES - 1)) boot <= 1'b1;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  irq_encoder #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk   (clk),
    .rst_n (rst_n),
    .irq_n (irq_n),
    .ipl_n (ipl_n)
  );

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed boot/wait/ext/timeout/IRQ
// steps followed by randomized reads and IRQ patterns against a table model.
module tb_bus_controller;

  localparam logic [23:0] WB [4] = '{24'hF00000, 24'h000000, 24'h800000, 24'h400000};
  localparam logic [23:0] WM [4] = '{24'hF00000, 24'hF00000, 24'hF00000, 24'hF00000};
  localparam int          WW [4] = '{1, 0, 0, 3};
  localparam bit          WX [4] = '{0, 0, 1, 0};
  localparam bit          VEC [7] = '{0, 0, 0, 0, 1, 0, 0};

  logic        clk = 0;
  logic        rst_n;
  logic        as_n, uds_n, lds_n, rw;
  logic [2:0]  fc;
  logic [22:0] addr;
  logic [3:0]  cs_n;
  logic [3:0]  dtack_in_n;
  logic        iack_dtack_n;
  logic [6:0]  irq_n;
  logic [6:0]  iack_n;
  logic [2:0]  ipl_n;
  logic        dtack_n, vpa_n, berr_n, boot;

  int total = 0;
  int bad   = 0;

  bus_controller #(
    .NUM_CS(4),
    .CS_BASE({WB[3], WB[2], WB[1], WB[0]}),
    .CS_MASK({WM[3], WM[2], WM[1], WM[0]}),
    .CS_WAIT({4'd3, 4'd0, 4'd0, 4'd1}),
    .CS_EXT(4'b0100),
    .BOOT_CS(0),
    .BOOT_CYCLES(4),
    .BERR_TIMEOUT(64),
    .NUM_IRQ(7),
    .IRQ_VECTORED(7'b0010000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .fc(fc), .addr(addr), .cs_n(cs_n), .dtack_in_n(dtack_in_n),
    .iack_dtack_n(iack_dtack_n), .irq_n(irq_n), .iack_n(iack_n),
    .ipl_n(ipl_n), .dtack_n(dtack_n), .vpa_n(vpa_n), .berr_n(berr_n),
    .boot(boot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: which window a plain access selects (-1 = unmapped).
  function automatic int model_win(input logic [23:0] a, input bit bt);
    if (!bt) return 0;
    for (int i = 0; i < 4; i++)
      if (((a ^ WB[i]) & WM[i]) == 24'h0) return i;
    return -1;
  endfunction

  // Reference: edges from AS sampled low to DTACK for a window.
  function automatic int model_lat(input int w, input int ack_at);
    return WX[w] ? ack_at + 1 : 2 + WW[w];
  endfunction

  function automatic logic [2:0] model_ipl(input logic [6:0] req);
    for (int i = 6; i >= 0; i--)
      if (req[i]) return ~3'(i + 1);
    return 3'b111;
  endfunction

  // One complete bus cycle. kind: 1=DTACK 2=VPA 3=BERR 0=nothing.
  // ack_at: edge index after which external/vectored acks are driven low.
  task automatic bus_cycle(input logic [23:0] a, input logic [2:0] f, input int ack_at,
                           output int lat, output int kind,
                           output logic [3:0] csl, output logic [6:0] ial);
    lat = -1; kind = 0; csl = '0; ial = '0;
    addr = a[23:1]; fc = f; rw = 1'b1; as_n = 0; uds_n = 0; lds_n = 0;
    for (int k = 0; k < 100 && kind == 0; k++) begin
      tick();
      csl |= ~cs_n;
      ial |= ~iack_n;
      if (!dtack_n) kind = 1;
      else if (!vpa_n) kind = 2;
      else if (!berr_n) kind = 3;
      if (kind != 0) lat = k;
      if (k == ack_at) begin dtack_in_n = '0; iack_dtack_n = 0; end
    end
    as_n = 1; uds_n = 1; lds_n = 1; dtack_in_n = '1; iack_dtack_n = 1;
    tick();
    chk("release", 32'({cs_n, iack_n, dtack_n, vpa_n, berr_n}), 32'h3FFF);
    tick();
  endtask

  int         lat, kind, w, ncyc, ack_at;
  logic [3:0] csl;
  logic [6:0] ial, req;
  logic [23:0] a;
  bit         boot_m;

  initial begin
    rst_n = 0; as_n = 1; uds_n = 1; lds_n = 1; rw = 1; fc = 3'd5; addr = '0;
    dtack_in_n = '1; iack_dtack_n = 1; irq_n = '1;
    repeat (3) tick();
    chk("rst_out", 32'({cs_n, iack_n, dtack_n, vpa_n, berr_n}), 32'h3FFF);
    chk("rst_ipl", 32'(ipl_n), 32'h7);
    chk("rst_boot", 32'(boot), 32'h0);
    rst_n = 1;
    tick();

    // Boot overlay: four reads of 0 hit BOOT_CS, fifth hits RAM.
    ncyc = 0;
    for (int i = 0; i < 5; i++) begin
      boot_m = (ncyc >= 4);
      w = model_win(24'h000000, boot_m);
      bus_cycle(24'h000000, 3'd5, -1, lat, kind, csl, ial);
      chk("boot_cs", 32'(csl), 32'(4'b0001 << w));
      chk("boot_lat", 32'(lat), 32'(model_lat(w, -1)));
      ncyc++;
      chk("boot_flag", 32'(boot), 32'(ncyc >= 4));
    end

    // Wait states: 3-wait window and zero-wait window.
    bus_cycle(24'h400000, 3'd5, -1, lat, kind, csl, ial);
    chk("wait3_lat", 32'(lat), 32'd5);
    chk("wait3_cs", 32'(csl), 32'(4'b1000));
    bus_cycle(24'h000100, 3'd5, -1, lat, kind, csl, ial);
    chk("wait0_lat", 32'(lat), 32'd2);

    // External ack driven after edge 10.
    bus_cycle(24'h800010, 3'd5, 10, lat, kind, csl, ial);
    chk("ext_lat", 32'(lat), 32'd11);
    chk("ext_kind", 32'(kind), 32'd1);
    chk("ext_cs", 32'(csl), 32'(4'b0100));

    // Unmapped address times out.
    bus_cycle(24'hA00000, 3'd5, -1, lat, kind, csl, ial);
    chk("to_kind", 32'(kind), 32'd3);
    chk("to_lat", 32'(lat), 32'd64);
    chk("to_cs", 32'(csl), 32'h0);

    // Interrupt encode: levels 2 and 5 asserted.
    irq_n = 7'b1101101;
    repeat (3) tick();
    chk("ipl_2_5", 32'(ipl_n), 32'(3'b010));

    // IACK level 5, vectored.
    bus_cycle(24'hFFFFF0 | 24'(5 << 1), 3'b111, 3, lat, kind, csl, ial);
    chk("iack5_ial", 32'(ial), 32'(7'b0010000));
    chk("iack5_kind", 32'(kind), 32'd1);
    chk("iack5_lat", 32'(lat), 32'd4);
    chk("iack5_ipl", 32'(ipl_n), 32'(3'b010));

    // IACK level 2, autovector.
    bus_cycle(24'hFFFFF0 | 24'(2 << 1), 3'b111, -1, lat, kind, csl, ial);
    chk("iack2_kind", 32'(kind), 32'd2);
    chk("iack2_ial", 32'(ial), 32'h0);
    chk("iack2_cs", 32'(csl), 32'h0);

    // IACK level 0 selects nothing.
    bus_cycle(24'hFFFFF0, 3'b111, -1, lat, kind, csl, ial);
    chk("iack0_kind", 32'(kind), 32'd3);
    chk("iack0_lat", 32'(lat), 32'd64);

    // Random reads against the window table.
    for (int i = 0; i < 20; i++) begin
      w = int'($urandom_range(0, 3));
      a = WB[w] | (24'($urandom) & 24'h0FFFFE);
      ack_at = WX[w] ? int'($urandom_range(2, 15)) : -1;
      w = model_win(a, 1'b1);
      bus_cycle(a, 3'd5, ack_at, lat, kind, csl, ial);
      chk("rnd_cs", 32'(csl), 32'(4'b0001 << w));
      chk("rnd_lat", 32'(lat), 32'(model_lat(w, ack_at)));
    end

    // Random interrupt patterns.
    for (int i = 0; i < 10; i++) begin
      req = 7'($urandom);
      irq_n = ~req;
      repeat (3) tick();
      chk("rnd_ipl", 32'(ipl_n), 32'(model_ipl(req)));
    end
    irq_n = '1;

    // Reset in the middle of a wait-state cycle.
    addr = 23'(24'h400000 >> 1); fc = 3'd5; as_n = 0; uds_n = 0; lds_n = 0;
    repeat (3) tick();
    chk("mid_cs_low", 32'(cs_n), 32'(4'b0111));
    rst_n = 0;
    #1;
    chk("mid_rst_out", 32'({cs_n, iack_n, dtack_n, vpa_n, berr_n}), 32'h3FFF);
    chk("mid_rst_boot", 32'(boot), 32'h0);
    as_n = 1; uds_n = 1; lds_n = 1;
    tick();
    rst_n = 1;
    tick();
    bus_cycle(24'h000000, 3'd5, -1, lat, kind, csl, ial);
    chk("post_rst_cs", 32'(csl), 32'(4'b0001));
    chk("post_rst_lat", 32'(lat), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
